contador_arbiter: RTL and testbench
===================================

// Module: contador_arbiter
// PURPOSE
//  Round-robin scheduler that shares one modulo counter (same function as contador) among
//  N_REQ requesters. Each requester supplies its own terminal value. The arbiter grants the
//  counter to one requester at a time and runs it from 0 up to that value. It then signals
//  completion and rotates priority. It sits between requesting FSMs and the counting datapath.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  WIDTH  3  counter / max value width in bits
// PORTS
//  clock     in   1            rising-edge clock
//  reset     in   1            asynchronous reset, active-low (0 = reset)
//  req       in   N_REQ        per-requester request, level, held until done/abort
//  max_bus   in   N_REQ*WIDTH  terminal value of requester i at [i*WIDTH +: WIDTH]
//  grant     out  N_REQ        one-hot owner of counter, all-zero when idle
//  count     out  WIDTH        current counter value
//  busy      out  1            1 in COUNT or DONE
//  done      out  1            1-cycle pulse: granted run reached its max
//  abort     out  1            1-cycle pulse: owner dropped req before done
//  done_id   out  clog2(N_REQ) index of owner for the done/abort pulse
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rr_ptr=0, grant=0, count=0, busy=0, done=0,
//   abort=0, done_id=0, max_q=0. All outputs are registered.
//  FSM states: IDLE, COUNT, DONE, ABORT.
//  IDLE: if req!=0, pick first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   On the next edge: state=COUNT, grant=1<<i, id_q=i, max_q=max_bus slice i, count=0.
//   If req==0, stay in IDLE. Grant latency is 1 cycle from sampled req.
//  COUNT: if req[id_q]=0, go to ABORT. Else if count==max_q, go to DONE with count held.
//   Otherwise count=count+1. The owner therefore sees count 0..max_q over max_q+1 cycles.
//   max_q=0 gives exactly 1 COUNT cycle.
//  DONE: done=1, done_id=id_q, grant still asserted, count=max_q for 1 cycle.
//   On the next edge: state=IDLE, grant=0, count=0, rr_ptr=(id_q+1) mod N_REQ.
//  ABORT: abort=1, done_id=id_q, grant=0, count=0 for 1 cycle.
//   On the next edge: state=IDLE, rr_ptr=(id_q+1) mod N_REQ.
//  max_bus is sampled only at grant. Later changes are ignored for the current run.
//  Requests from non-owners during COUNT/DONE/ABORT are not lost. They are arbitrated in the
//   next IDLE cycle, so there is at least 1 IDLE cycle between runs.
//  Owner drops req in the same cycle count==max_q: abort has priority, so no done pulse.
//  Arithmetic: count is WIDTH bits and never wraps, because count<=max_q<=2^WIDTH-1.
//   max=7 with WIDTH=3 runs 0..7, then DONE.
//  Exactly one of grant bits is set whenever busy=1. done and abort are never both 1.
//  reset asserted mid-run: immediate return to reset values. No done/abort pulse.
//   rr_ptr=0 afterwards.
// TESTING
//  1 Reset: reset=0 with req=4'b1111 -> grant=0, count=0, busy=0, done=0; stays so until
//    reset=1.
//  2 Single req: req=4'b0100, max2=6 -> grant=4'b0100 one cycle later; count 0..6 over
//    7 cycles; done=1 with done_id=2, count=6; then IDLE, grant=0.
//  3 Round robin: req=4'b1111 held, max=1 each -> grant order 0001,0010,0100,1000,0001;
//    4 cycles per run (COUNT x2, DONE, IDLE).
//  4 Boundaries: max=0 -> 1 COUNT cycle then done. max=7 -> count reaches 7, no wrap.
//    Change max_bus mid-run -> no effect.
//  5 Abort: owner 1 drops req at count=3, max=5 -> abort=1, done_id=1, done=0; next grant
//    goes to lowest pending index >=2.
//  6 Async reset mid-run at count=4 -> outputs reset within the same cycle (before the next
//    edge); after release, req=4'b0011 -> grant=4'b0001.

Source files
------------

// File: rtl/contador_arbiter.sv
// Round-robin arbiter sharing one 0..max counter among N_REQ requesters.
// The granted requester's terminal value is latched at grant; completion or abort rotates priority.
module contador_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WIDTH-1:0]     max_bus,
   output logic [N_REQ-1:0]           grant,
   output logic [WIDTH-1:0]           count,
   output logic                       busy,
   output logic                       done,
   output logic                       abort,
   output logic [$clog2(N_REQ)-1:0]   done_id
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE, S_ABORT} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  max_q, max_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;
   logic [ID_W-1:0]   done_id_q, done_id_d;

   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic [WIDTH-1:0]  pick_max;
   logic [ID_W-1:0]   next_ptr;
   int                idx;

   // First requester at or after rr_ptr_q, wrapping modulo N_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_max   = '0;
      idx        = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'(idx);
            pick_max   = max_bus[idx*WIDTH +: WIDTH];
         end
      end
   end

   assign next_ptr = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

   // NOTE: every flop, including the latched max and owner id, is cleared so a mid-run reset leaves no stale run behind.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         max_q     <= '0;
         count_q   <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         done_id_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         max_q     <= max_d;
         count_q   <= count_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         done_id_q <= done_id_d;
      end
   end

   // Abort outranks done when the owner drops req on its final count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_found) state_d = S_COUNT;
         S_COUNT: begin
            if (!req[id_q])            state_d = S_ABORT;
            else if (count_q == max_q) state_d = S_DONE;
         end
         S_DONE, S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      max_d     = max_q;
      count_d   = count_q;
      grant_d   = grant_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      done_id_d = done_id_q;
      case (state_q)
         S_IDLE: begin
            if (state_d == S_COUNT) begin
               id_d    = pick_idx;
               max_d   = pick_max;
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
         S_COUNT: begin
            case (state_d)
               S_ABORT: begin
                  abort_d   = 1'b1;
                  done_id_d = id_q;
                  grant_d   = '0;
                  count_d   = '0;
               end
               S_DONE: begin
                  done_d    = 1'b1;
                  done_id_d = id_q;
                  busy_d    = 1'b1;
               end
               default: begin
                  count_d = count_q + 1'b1;
                  busy_d  = 1'b1;
               end
            endcase
         end
         S_DONE, S_ABORT: begin
            grant_d  = '0;
            count_d  = '0;
            rr_ptr_d = next_ptr;
         end
         default: ;
      endcase
   end

   assign grant   = grant_q;
   assign count   = count_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign abort   = abort_q;
   assign done_id = done_id_q;

endmodule

// File: tb/tb_contador_arbiter.sv
// Directed bench for contador_arbiter: per-cycle vector tables plus hand-written reset/abort sequences.
module tb_contador_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 3;

   typedef struct {
      logic [3:0]  req;
      logic [11:0] max_bus;
      logic [3:0]  grant;
      logic [2:0]  count;
      logic        busy;
      logic        done;
      logic        abort;
      logic [1:0]  id;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] max_bus;
   logic [3:0]  grant;
   logic [2:0]  count;
   logic        busy;
   logic        done;
   logic        abort;
   logic [1:0]  done_id;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   contador_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .max_bus (max_bus),
      .grant   (grant),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .abort   (abort),
      .done_id (done_id)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic [2:0] c,
                             input logic b, input logic d, input logic a);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".busy"},  32'(busy),  32'(b));
      check({tag, ".done"},  32'(done),  32'(d));
      check({tag, ".abort"}, 32'(abort), 32'(a));
   endtask

   function automatic void add(input logic [3:0] r, input logic [11:0] m, input logic [3:0] g,
                               input logic [2:0] c, input logic b, input logic d, input logic a,
                               input logic [1:0] id);
      vec_t v;
      v.req = r; v.max_bus = m; v.grant = g; v.count = c;
      v.busy = b; v.done = d; v.abort = a; v.id = id;
      vecs.push_back(v);
   endfunction

   task automatic run_vecs(input string tag);
      string t;
      foreach (vecs[i]) begin
         req     = vecs[i].req;
         max_bus = vecs[i].max_bus;
         step();
         t = $sformatf("%s[%0d]", tag, i);
         check_outs(t, vecs[i].grant, vecs[i].count, vecs[i].busy, vecs[i].done, vecs[i].abort);
         if (vecs[i].done || vecs[i].abort)
            check({t, ".done_id"}, 32'(done_id), 32'(vecs[i].id));
      end
      vecs.delete();
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      req     = '0;
      max_bus = '0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with all requests asserted: nothing may be granted.
      reset   = 1'b0;
      req     = 4'b1111;
      max_bus = 12'h249;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("reset_hold[%0d]", i), 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
      end
      req   = 4'b0000;
      reset = 1'b1;

      // Single requester 2 with max 6.
      for (int c = 0; c <= 6; c++) add(4'b0100, 12'h180, 4'b0100, 3'(c), 1, 0, 0, 0);
      add(4'b0100, 12'h180, 4'b0100, 3'd6, 1, 1, 0, 2'd2);
      add(4'b0000, 12'h180, 4'b0000, 3'd0, 0, 0, 0, 0);
      add(4'b0000, 12'h180, 4'b0000, 3'd0, 0, 0, 0, 0);
      run_vecs("single");

      // Round robin, all requesting, max 1 each.
      do_reset();
      for (int r = 0; r < 5; r++) begin
         logic [3:0] g;
         g = 4'b0001 << (r % 4);
         add(4'b1111, 12'h249, g, 3'd0, 1, 0, 0, 0);
         add(4'b1111, 12'h249, g, 3'd1, 1, 0, 0, 0);
         add(4'b1111, 12'h249, g, 3'd1, 1, 1, 0, 2'(r % 4));
         add(4'b1111, 12'h249, 4'b0000, 3'd0, 0, 0, 0, 0);
      end
      run_vecs("rr");

      // max 0: one COUNT cycle, then done.
      do_reset();
      add(4'b0001, 12'hFF8, 4'b0001, 3'd0, 1, 0, 0, 0);
      add(4'b0001, 12'hFF8, 4'b0001, 3'd0, 1, 1, 0, 2'd0);
      add(4'b0000, 12'hFF8, 4'b0000, 3'd0, 0, 0, 0, 0);
      run_vecs("max0");

      // max 7 on requester 3, max_bus lowered mid-run must be ignored.
      do_reset();
      for (int c = 0; c <= 7; c++)
         add(4'b1000, (c < 3) ? 12'hE00 : 12'h400, 4'b1000, 3'(c), 1, 0, 0, 0);
      add(4'b1000, 12'h400, 4'b1000, 3'd7, 1, 1, 0, 2'd3);
      add(4'b0000, 12'h400, 4'b0000, 3'd0, 0, 0, 0, 0);
      run_vecs("max7");

      // Owner 1 drops req at count 3 of max 5; next pending is index 2.
      do_reset();
      for (int c = 0; c <= 3; c++) add(4'b1110, 12'h028, 4'b0010, 3'(c), 1, 0, 0, 0);
      add(4'b1100, 12'h028, 4'b0000, 3'd0, 0, 0, 1, 2'd1);
      add(4'b1100, 12'h028, 4'b0000, 3'd0, 0, 0, 0, 0);
      add(4'b1100, 12'h028, 4'b0100, 3'd0, 1, 0, 0, 0);
      run_vecs("abort");

      // Owner drops req on the very cycle count reaches max: abort wins.
      do_reset();
      for (int c = 0; c <= 2; c++) add(4'b0001, 12'h002, 4'b0001, 3'(c), 1, 0, 0, 0);
      add(4'b0000, 12'h002, 4'b0000, 3'd0, 0, 0, 1, 2'd0);
      add(4'b0000, 12'h002, 4'b0000, 3'd0, 0, 0, 0, 0);
      run_vecs("abort_at_max");

      // Async reset mid-run at count 4, then fresh arbitration from index 0.
      do_reset();
      req     = 4'b0100;
      max_bus = 12'h180;
      for (int c = 0; c <= 4; c++) step();
      check_outs("pre_async", 4'b0100, 3'd4, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 check_outs("async_now", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      check_outs("async_held", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      req   = 4'b0011;
      step();
      check_outs("after_async", 4'b0001, 3'd0, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
